nh_lcd_cmd_sequencer: RTL and testbench

Sequences a full LCD controller transaction for the NH LCD path: one command byte followed by 0-4 parameter bytes, written or read back. It sits directly upstream of the single-byte command engine and drives that engine's strobe/finished handshake one byte at a time. It exposes a simple start/done interface to the wishbone register layer.

---
 rtl/nh_lcd_cmd_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_nh_lcd_cmd_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/nh_lcd_cmd_sequencer.sv
// Sequences one LCD controller transaction (command byte plus 0-4 parameter
// bytes, written or read back) over the single-byte command engine handshake.
module nh_lcd_cmd_sequencer #(
    parameter int GAP_CYCLES = 0,
    parameter int TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic [7:0]  i_cmd,
    input  logic [2:0]  i_param_count,
    input  logic        i_read,
    input  logic [31:0] i_param_data,
    output logic [31:0] o_read_data,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error,
    output logic        o_enable,
    output logic        o_cmd_write_stb,
    output logic        o_cmd_read_stb,
    output logic [7:0]  o_cmd_data,
    output logic        o_cmd_parameter,
    input  logic [7:0]  i_cmd_data,
    input  logic        i_cmd_finished
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_GAP   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t      state_r;
    logic [7:0]  cmd_r;
    logic [2:0]  count_r;
    logic        read_r;
    logic [31:0] pdata_r;
    logic [2:0]  idx_r;
    logic [7:0]  to_cnt_r;
    logic [3:0]  gap_cnt_r;

    logic [2:0]  issue_idx_s;
    logic [7:0]  issue_data_s;
    logic        issue_param_s;
    logic        issue_rd_s;

    assign o_enable = o_busy;

    // Byte to present on the next strobe: GAP already advanced the index, WAIT has not yet.
    always_comb begin
        issue_idx_s = idx_r + 3'd1;
        if (state_r == S_GAP) begin
            issue_idx_s = idx_r;
        end else begin
            issue_idx_s = idx_r + 3'd1;
        end
        case (issue_idx_s)
            3'd1:    issue_data_s = pdata_r[7:0];
            3'd2:    issue_data_s = pdata_r[15:8];
            3'd3:    issue_data_s = pdata_r[23:16];
            3'd4:    issue_data_s = pdata_r[31:24];
            default: issue_data_s = cmd_r;
        endcase
        issue_param_s = (issue_idx_s != 3'd0);
        issue_rd_s    = read_r && issue_param_s;
    end

    // Transaction FSM; all handshake outputs are registered on the transition edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r         <= S_IDLE;
            cmd_r           <= 8'h00;
            count_r         <= 3'd0;
            read_r          <= 1'b0;
            pdata_r         <= 32'h0000_0000;
            idx_r           <= 3'd0;
            to_cnt_r        <= 8'd0;
            gap_cnt_r       <= 4'd0;
            o_read_data     <= 32'h0000_0000;
            o_busy          <= 1'b0;
            o_done          <= 1'b0;
            o_error         <= 1'b0;
            o_cmd_write_stb <= 1'b0;
            o_cmd_read_stb  <= 1'b0;
            o_cmd_data      <= 8'h00;
            o_cmd_parameter <= 1'b0;
        end else begin
            o_cmd_write_stb <= 1'b0;
            o_cmd_read_stb  <= 1'b0;
            o_done          <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (i_start) begin
                        cmd_r   <= i_cmd;
                        count_r <= i_param_count;
                        read_r  <= i_read;
                        pdata_r <= i_param_data;
                        idx_r   <= 3'd0;
                        if (i_param_count > 3'd4) begin
                            state_r <= S_DONE;
                            o_done  <= 1'b1;
                            o_error <= 1'b1;
                        end else begin
                            state_r         <= S_ISSUE;
                            o_busy          <= 1'b1;
                            o_cmd_write_stb <= 1'b1;
                            o_cmd_data      <= i_cmd;
                            o_cmd_parameter <= 1'b0;
                            if (i_read) begin
                                o_read_data <= 32'h0000_0000;
                            end
                        end
                    end
                end
                S_ISSUE: begin
                    state_r  <= S_WAIT;
                    to_cnt_r <= 8'd0;
                end
                S_WAIT: begin
                    if (i_cmd_finished) begin
                        if (read_r) begin
                            case (idx_r)
                                3'd1:    o_read_data[7:0]   <= i_cmd_data;
                                3'd2:    o_read_data[15:8]  <= i_cmd_data;
                                3'd3:    o_read_data[23:16] <= i_cmd_data;
                                3'd4:    o_read_data[31:24] <= i_cmd_data;
                                default: o_read_data        <= o_read_data;
                            endcase
                        end
                        if (idx_r == count_r) begin
                            state_r <= S_DONE;
                            o_done  <= 1'b1;
                            o_busy  <= 1'b0;
                        end else begin
                            idx_r <= idx_r + 3'd1;
                            if (GAP_CYCLES > 0) begin
                                state_r   <= S_GAP;
                                gap_cnt_r <= 4'd0;
                            end else begin
                                state_r         <= S_ISSUE;
                                o_cmd_write_stb <= !issue_rd_s;
                                o_cmd_read_stb  <= issue_rd_s;
                                o_cmd_data      <= issue_data_s;
                                o_cmd_parameter <= issue_param_s;
                            end
                        end
                    end else if (to_cnt_r >= 8'(TIMEOUT - 1)) begin
                        state_r <= S_DONE;
                        o_done  <= 1'b1;
                        o_error <= 1'b1;
                        o_busy  <= 1'b0;
                    end else begin
                        to_cnt_r <= to_cnt_r + 8'd1;
                    end
                end
                S_GAP: begin
                    if (gap_cnt_r >= 4'(GAP_CYCLES - 1)) begin
                        state_r         <= S_ISSUE;
                        o_cmd_write_stb <= !issue_rd_s;
                        o_cmd_read_stb  <= issue_rd_s;
                        o_cmd_data      <= issue_data_s;
                        o_cmd_parameter <= issue_param_s;
                    end else begin
                        gap_cnt_r <= gap_cnt_r + 4'd1;
                    end
                end
                S_DONE: begin
                    state_r <= S_IDLE;
                    o_error <= 1'b0;
                end
                default: begin
                    state_r <= S_IDLE;
                    o_busy  <= 1'b0;
                    o_error <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nh_lcd_cmd_sequencer.sv
// Directed bench for nh_lcd_cmd_sequencer: a vector table of whole transactions
// plus hand-written timeout, gap and mid-transaction reset sequences.
module tb_nh_lcd_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  cmd;
    logic [2:0]  pcnt;
    logic        rdreq;
    logic [31:0] pdata;

    logic [31:0] rdata0, rdata1;
    logic        busy0, done0, err0, en0, wr0, rd0, par0;
    logic        busy1, done1, err1, en1, wr1, rd1, par1;
    logic [7:0]  cdata0, cdata1;
    logic [7:0]  ed0, ed1;
    logic        ef0, ef1;
    logic        eng0_en, eng1_en;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    nh_lcd_cmd_sequencer #(.GAP_CYCLES(0), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(start), .i_cmd(cmd),
        .i_param_count(pcnt), .i_read(rdreq), .i_param_data(pdata),
        .o_read_data(rdata0), .o_busy(busy0), .o_done(done0), .o_error(err0),
        .o_enable(en0), .o_cmd_write_stb(wr0), .o_cmd_read_stb(rd0),
        .o_cmd_data(cdata0), .o_cmd_parameter(par0),
        .i_cmd_data(ed0), .i_cmd_finished(ef0)
    );

    nh_lcd_cmd_sequencer #(.GAP_CYCLES(2), .TIMEOUT(8)) dut_gap (
        .clk(clk), .rst_n(rst_n), .i_start(start), .i_cmd(cmd),
        .i_param_count(pcnt), .i_read(rdreq), .i_param_data(pdata),
        .o_read_data(rdata1), .o_busy(busy1), .o_done(done1), .o_error(err1),
        .o_enable(en1), .o_cmd_write_stb(wr1), .o_cmd_read_stb(rd1),
        .o_cmd_data(cdata1), .o_cmd_parameter(par1),
        .i_cmd_data(ed1), .i_cmd_finished(ef1)
    );

    // Engine models: finished two cycles after a strobe; k-th read byte returns 0x11*k.
    logic       p0, p1;
    logic [7:0] rn0, rn1;
    always @(posedge clk) begin
        p0  <= eng0_en && (wr0 || rd0);
        ef0 <= p0;
        ed0 <= p0 ? 8'h11 * rn0 : 8'h00;
        if (wr0 && !par0) rn0 <= 8'd0;
        else if (rd0) rn0 <= rn0 + 8'd1;
        p1  <= eng1_en && (wr1 || rd1);
        ef1 <= p1;
        ed1 <= p1 ? 8'h11 * rn1 : 8'h00;
        if (wr1 && !par1) rn1 <= 8'd0;
        else if (rd1) rn1 <= rn1 + 8'd1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0]  cmd;
        logic [2:0]  cnt;
        logic        rd;
        logic [31:0] pd;
        int          done_cyc;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs [6];

    task automatic run_vec(input vec_t v);
        int nstb, busy_n, done_cyc;
        logic err_s;
        logic [31:0] rd_s, sh;
        logic [10:0] exp_s, act_s;
        nstb = 0; busy_n = 0; done_cyc = 0; err_s = 1'b0; rd_s = 32'h0;
        @(negedge clk);
        cmd = v.cmd; pcnt = v.cnt; rdreq = v.rd; pdata = v.pd; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 60 && done_cyc == 0; c++) begin
            @(negedge clk);
            if (wr0 || rd0) begin
                check("one_stb", {62'h0, wr0 & rd0}, 64'h0);
                if (nstb == 0) begin
                    exp_s = {1'b0, 1'b1, 1'b0, v.cmd};
                end else begin
                    sh = v.pd >> (8 * (nstb - 1));
                    exp_s = {v.rd, !v.rd, 1'b1, v.rd ? 8'h00 : sh[7:0]};
                end
                act_s = {rd0, wr0, par0, rd0 ? 8'h00 : cdata0};
                check("strobe", {53'h0, act_s}, {53'h0, exp_s});
                nstb++;
            end
            if (busy0) busy_n++;
            if (done0) begin
                done_cyc = c; err_s = err0; rd_s = rdata0;
            end
        end
        check("done_cycle", 64'(done_cyc), 64'(v.done_cyc));
        check("error", {63'h0, err_s}, {63'h0, v.err});
        check("read_data", {32'h0, rd_s}, {32'h0, v.rdata});
        check("strobe_count", 64'(nstb), 64'((v.cnt > 3'd4) ? 0 : v.cnt + 1));
        check("busy_cycles", 64'(busy_n), 64'((v.cnt > 3'd4) ? 0 : v.done_cyc - 1));
        @(negedge clk);
        check("idle_after", {61'h0, done0, busy0, err0}, 64'h0);
    endtask

    initial begin
        int done_cyc, nstb, dn;
        int stb_cyc [3];
        logic [7:0] stb_dat [3];
        vecs[0] = '{8'h2A, 3'd4, 1'b0, 32'h0100_00EF, 16, 1'b0, 32'h0000_0000};
        vecs[1] = '{8'h04, 3'd3, 1'b1, 32'hDEAD_BEEF, 13, 1'b0, 32'h0033_2211};
        vecs[2] = '{8'h29, 3'd0, 1'b0, 32'h0000_0000,  4, 1'b0, 32'h0033_2211};
        vecs[3] = '{8'h33, 3'd5, 1'b0, 32'h1234_5678,  1, 1'b1, 32'h0033_2211};
        vecs[4] = '{8'h0A, 3'd1, 1'b1, 32'h0000_0000,  7, 1'b0, 32'h0000_0011};
        vecs[5] = '{8'h36, 3'd2, 1'b0, 32'h0000_BEEF, 10, 1'b0, 32'h0000_0011};

        rst_n = 1'b0; start = 1'b0; cmd = 8'h00; pcnt = 3'd0; rdreq = 1'b0;
        pdata = 32'h0; eng0_en = 1'b1; eng1_en = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_dut", {rdata0, 11'h0, busy0, done0, err0, en0, wr0, rd0, par0, cdata0}, 64'h0);
        check("reset_gap", {rdata1, 11'h0, busy1, done1, err1, en1, wr1, rd1, par1, cdata1}, 64'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Engine silent: abort after 8 WAIT cycles; a start while busy is ignored.
        eng0_en = 1'b0;
        @(negedge clk);
        cmd = 8'h2C; pcnt = 3'd1; rdreq = 1'b0; pdata = 32'h55; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        done_cyc = 0; nstb = 0;
        for (int c = 1; c <= 40 && done_cyc == 0; c++) begin
            @(negedge clk);
            if (wr0 || rd0) nstb++;
            if (c == 5) check("wait_hold", {55'h0, par0, cdata0}, {55'h0, 1'b0, 8'h2C});
            if (done0) begin
                done_cyc = c;
                check("timeout_err", {63'h0, err0}, 64'h1);
            end
            if (c == 3) begin
                cmd = 8'h99; pcnt = 3'd0; start = 1'b1;
            end
            if (c == 4) start = 1'b0;
        end
        check("timeout_cycle", 64'(done_cyc), 64'd10);
        check("timeout_stbs", 64'(nstb), 64'd1);
        eng0_en = 1'b1;
        repeat (20) @(negedge clk);

        // GAP_CYCLES=2: strobes at cycles 1, 6, 11 and done at 14.
        @(negedge clk);
        cmd = 8'h2B; pcnt = 3'd2; rdreq = 1'b0; pdata = 32'h0000_1234; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        done_cyc = 0; nstb = 0;
        for (int c = 1; c <= 40 && done_cyc == 0; c++) begin
            @(negedge clk);
            if (wr1 || rd1) begin
                if (nstb < 3) begin
                    stb_cyc[nstb] = c; stb_dat[nstb] = cdata1;
                end
                nstb++;
            end
            if (done1) done_cyc = c;
        end
        check("gap_stbs", 64'(nstb), 64'd3);
        check("gap_cyc0", 64'(stb_cyc[0]), 64'd1);
        check("gap_cyc1", 64'(stb_cyc[1]), 64'd6);
        check("gap_cyc2", 64'(stb_cyc[2]), 64'd11);
        check("gap_data", {40'h0, stb_dat[0], stb_dat[1], stb_dat[2]}, {40'h0, 8'h2B, 8'h34, 8'h12});
        check("gap_done", 64'(done_cyc), 64'd14);
        repeat (5) @(negedge clk);

        // Reset asserted in WAIT: outputs clear next cycle and no done follows.
        @(negedge clk);
        check("pre_reset_rdata", {32'h0, rdata0}, {32'h0, 32'h0000_0011});
        cmd = 8'h3A; pcnt = 3'd2; rdreq = 1'b0; pdata = 32'h0000_7788; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("in_wait_busy", {63'h0, busy0}, 64'h1);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_reset", {rdata0, 11'h0, busy0, done0, err0, en0, wr0, rd0, par0, cdata0}, 64'h0);
        rst_n = 1'b1;
        dn = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done0 || wr0 || rd0) dn++;
        end
        check("no_done_after_reset", 64'(dn), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
